// File: rtl/simon_if.sv
// Player-facing bundle of the Simon core: debounced step, level, switches, LEDs and outcome.
// The engine attaches through the slave modport; the board/bench drives through master.
interface simon_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
);
  logic                         step;
  logic                         level;
  logic [WIDTH-1:0]             pattern;
  logic [WIDTH-1:0]             pattern_leds;
  logic [2:0]                   mode_leds;
  logic [$clog2(DEPTH+1)-1:0]   score;
  logic                         win;
  logic                         lose;

  modport master (
    output step, level, pattern,
    input  pattern_leds, mode_leds, score, win, lose
  );

  modport slave (
    input  step, level, pattern,
    output pattern_leds, mode_leds, score, win, lose
  );
endinterface

// File: rtl/simon_engine.sv
// Simon game core: control FSM plus sequence memory, win/lose outcome and score.
// Define SIMON_TIMEOUT_EN to lose the game when REPEAT sits idle for TIMEOUT_CYCLES.
module simon_engine #(
  parameter int WIDTH          = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic     clk,
  input  logic     rst,
  simon_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  // TIMEOUT_CYCLES is always positive; folding it in keeps it referenced in builds without the timeout.
  localparam int IW = (DEPTH > 1 && TIMEOUT_CYCLES > 0) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_INPUT,
    S_PLAYBACK,
    S_REPEAT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    n;
  logic [IW-1:0]    i;
  logic             lvl_q;
  logic             win_q;
  logic             lose_q;
  logic [2:0]       mode_q;

  logic             at_last;
  logic             pat_ok;
  logic             match;

  assign at_last = (CW'(i) == (n - CW'(1)));
  assign pat_ok  = (bus.pattern != '0) && (lvl_q || $onehot(bus.pattern));
  assign match   = (bus.pattern == mem[i]);

`ifdef SIMON_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside REPEAT, so entering REPEAT always starts a fresh window.
  always_ff @(posedge clk) begin
    if (!rst || state != S_REPEAT || bus.step) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`endif

  // Sequence memory is deliberately not reset; n gates which entries are ever shown.
  always_ff @(posedge clk) begin
    if (rst && state == S_INPUT && bus.step && pat_ok) begin
      mem[IW'(n)] <= bus.pattern;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_INPUT;
      mode_q <= 3'b001;
      n      <= '0;
      i      <= '0;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
      lvl_q  <= bus.level;
    end else if (bus.step) begin
      case (state)
        S_INPUT: begin
          if (pat_ok) begin
            n      <= n + CW'(1);
            i      <= '0;
            state  <= S_PLAYBACK;
            mode_q <= 3'b010;
          end
        end
        S_PLAYBACK: begin
          if (at_last) begin
            i      <= '0;
            state  <= S_REPEAT;
            mode_q <= 3'b100;
          end else begin
            i <= i + IW'(1);
          end
        end
        S_REPEAT: begin
          if (!match) begin
            lose_q <= 1'b1;
            i      <= '0;
            state  <= S_DONE;
            mode_q <= 3'b111;
          end else if (at_last) begin
            if (n == CW'(DEPTH)) begin
              win_q  <= 1'b1;
              i      <= '0;
              state  <= S_DONE;
              mode_q <= 3'b111;
            end else begin
              state  <= S_INPUT;
              mode_q <= 3'b001;
            end
          end else begin
            i <= i + IW'(1);
          end
        end
        S_DONE: begin
          i <= at_last ? '0 : i + IW'(1);
        end
      endcase
`ifdef SIMON_TIMEOUT_EN
    end else if (state == S_REPEAT && tmo_hit) begin
      lose_q <= 1'b1;
      i      <= '0;
      state  <= S_DONE;
      mode_q <= 3'b111;
`endif
    end
  end

  assign bus.pattern_leds = (state == S_INPUT || state == S_REPEAT) ? bus.pattern : mem[i];
  assign bus.mode_leds    = mode_q;
  assign bus.score        = n;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

endmodule
